// File: rtl/ppu_pkg.sv
// Shared PPU definitions: secondary-OAM default geometry, fill value and FSM state type.
package ppu_pkg;

    localparam int OAM2_DEPTH_DEF   = 8;
    localparam int OAM2_ENTRY_W_DEF = 32;

    localparam logic [OAM2_ENTRY_W_DEF-1:0] OAM2_FILL = {OAM2_ENTRY_W_DEF{1'b1}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } oam2_state_t;

endpackage

// File: rtl/ppu_oam2_ram.sv
// Secondary-OAM storage: DEPTH x ENTRY_W, one write port, one registered read port (read-before-write).
module ppu_oam2_ram #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [ENTRY_W-1:0]       i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [ENTRY_W-1:0]       o_rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rdata_q;

    // Array itself is never reset; contents are defined by the first clear or push.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Nonblocking update gives old contents on a same-address read/write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/ppu_oam2_buf.sv
// Secondary-OAM buffer: push/append, indexed read, hardware clear sequence, fill count.
// Optional macro PPU_OAM2_OVERFLOW_EN builds the sticky overflow flag (tied to 0 otherwise).
module ppu_oam2_buf
    import ppu_pkg::*;
#(
    parameter int                 DEPTH   = OAM2_DEPTH_DEF,
    parameter int                 ENTRY_W = OAM2_ENTRY_W_DEF,
    parameter logic [ENTRY_W-1:0] FILL    = {ENTRY_W{1'b1}}
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear_start,
    output logic                     o_clear_busy,
    input  logic                     i_push,
    input  logic [ENTRY_W-1:0]       i_push_data,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [ENTRY_W-1:0]       o_rd_data,
    output logic                     o_rd_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    oam2_state_t        state_q;
    logic [AW-1:0]      clr_cnt_q;
    logic [CW-1:0]      count_q;
    logic               rd_valid_q;
    logic               full;
    logic               clearing;
    logic               push_acc;
    logic               wr_en_d;
    logic [AW-1:0]      wr_addr_d;
    logic [ENTRY_W-1:0] wr_data_d;

    assign full     = (count_q == CW'(DEPTH));
    assign clearing = (state_q == S_CLEAR);
    // A clear request in the same cycle takes priority over the push.
    assign push_acc = !clearing && !i_clear_start && i_push && !full;

    // Reset gates the write so an aborted clear leaves later entries untouched.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = count_q[AW-1:0];
        wr_data_d = i_push_data;
        if (!i_rst) begin
            if (clearing) begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = FILL;
            end else if (push_acc) begin
                wr_en_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= i_rd_en;
            if (i_clear_start) begin
                state_q   <= S_CLEAR;
                clr_cnt_q <= '0;
                count_q   <= '0;
            end else begin
                case (state_q)
                    S_CLEAR: begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                        if (clr_cnt_q == AW'(DEPTH - 1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        if (push_acc) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef PPU_OAM2_OVERFLOW_EN
    logic ovf_q;
    logic push_ovf;

    assign push_ovf = !clearing && !i_clear_start && i_push && full;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_start) begin
            ovf_q <= 1'b0;
        end else if (push_ovf) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_overflow = ovf_q;
`else
    assign o_overflow = 1'b0;
`endif

    ppu_oam2_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (wr_en_d),
        .i_waddr (wr_addr_d),
        .i_wdata (wr_data_d),
        .i_re    (i_rd_en),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

    assign o_clear_busy = clearing;
    assign o_full       = full;
    assign o_count      = count_q;
    assign o_rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_ppu_oam2_buf.sv
// Directed bench for ppu_oam2_buf: default 8x32 instance plus a 16x40 instance.
module tb_ppu_oam2_buf;

`ifdef PPU_OAM2_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8 x 32 instance
    logic        a_clr = 1'b0, a_busy, a_push = 1'b0, a_full, a_ovf, a_rd_en = 1'b0, a_rd_valid;
    logic [31:0] a_pdata = '0, a_rdata;
    logic [3:0]  a_count;
    logic [2:0]  a_raddr = '0;

    // 16 x 40 instance
    logic        b_clr = 1'b0, b_busy, b_push = 1'b0, b_full, b_ovf, b_rd_en = 1'b0, b_rd_valid;
    logic [39:0] b_pdata = '0, b_rdata;
    logic [4:0]  b_count;
    logic [3:0]  b_raddr = '0;

    int total = 0;
    int bad   = 0;

    ppu_oam2_buf dut_a (
        .i_clk(clk), .i_rst(rst), .i_clear_start(a_clr), .o_clear_busy(a_busy),
        .i_push(a_push), .i_push_data(a_pdata), .o_full(a_full), .o_count(a_count),
        .o_overflow(a_ovf), .i_rd_en(a_rd_en), .i_rd_addr(a_raddr),
        .o_rd_data(a_rdata), .o_rd_valid(a_rd_valid)
    );

    ppu_oam2_buf #(.DEPTH(16), .ENTRY_W(40)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clear_start(b_clr), .o_clear_busy(b_busy),
        .i_push(b_push), .i_push_data(b_pdata), .o_full(b_full), .o_count(b_count),
        .o_overflow(b_ovf), .i_rd_en(b_rd_en), .i_rd_addr(b_raddr),
        .o_rd_data(b_rdata), .o_rd_valid(b_rd_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        a_rd_en = 1'b1;
        a_raddr = addr;
        tick();
        a_rd_en = 1'b0;
        check({tag, "_data"}, a_rdata, exp);
        check({tag, "_valid"}, a_rd_valid, 1'b1);
    endtask

    task automatic a_push1(input logic [31:0] d);
        a_push  = 1'b1;
        a_pdata = d;
        tick();
        a_push  = 1'b0;
    endtask

    task automatic a_run_clear(input string tag);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_busy%0d", tag, i), a_busy, 1'b1);
            tick();
        end
        check({tag, "_busy_end"}, a_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", a_busy, 1'b0);
        check("rst_full", a_full, 1'b0);
        check("rst_count", a_count, 4'd0);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_rvalid", a_rd_valid, 1'b0);

        // Clear, then every entry reads the fill value.
        a_run_clear("clr1");
        for (int a = 0; a < 8; a++) a_read(3'(a), 32'hFFFF_FFFF, $sformatf("fill%0d", a));
        tick();
        check("idle_rvalid", a_rd_valid, 1'b0);
        check("idle_rdata_hold", a_rdata, 32'hFFFF_FFFF);

        // Two pushes, read them back.
        a_push1(32'h1122_3344);
        a_push1(32'h5566_7788);
        check("push2_count", a_count, 4'd2);
        check("push2_full", a_full, 1'b0);
        a_read(3'd1, 32'h5566_7788, "rd1");
        a_read(3'd0, 32'h1122_3344, "rd0");

        // Fill up, then one push while full.
        for (int i = 2; i <= 8; i++) a_push1(32'hA000_0000 + 32'(i));
        check("full_count", a_count, 4'd8);
        check("full_full", a_full, 1'b1);
        check("full_ovf", a_ovf, OVF_EN);
        a_read(3'd7, 32'hA000_0007, "rd7");
        check("ovf_sticky", a_ovf, OVF_EN);

        // Clear start zeroes count and overflow on the same edge.
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check("clr2_count", a_count, 4'd0);
        check("clr2_ovf", a_ovf, 1'b0);
        check("clr2_full", a_full, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("clr2_done", a_busy, 1'b0);

        // Push together with clear start: clear wins, push during clear is dropped.
        a_push  = 1'b1;
        a_pdata = 32'hDEAD_BEEF;
        a_clr   = 1'b1;
        tick();
        a_clr   = 1'b0;
        check("pc_count0", a_count, 4'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pc_busy%0d", i), a_busy, 1'b1);
            tick();
        end
        a_push = 1'b0;
        check("pc_busy_end", a_busy, 1'b0);
        check("pc_count_end", a_count, 4'd0);
        check("pc_ovf_end", a_ovf, 1'b0);
        a_read(3'd0, 32'hFFFF_FFFF, "pc_rd0");

        // Read-before-write on the same entry.
        a_rd_en = 1'b1;
        a_raddr = 3'd0;
        a_push  = 1'b1;
        a_pdata = 32'h1234_5678;
        tick();
        a_rd_en = 1'b0;
        a_push  = 1'b0;
        check("rbw_old", a_rdata, 32'hFFFF_FFFF);
        check("rbw_count", a_count, 4'd1);
        a_read(3'd0, 32'h1234_5678, "rbw_new");

        // Reset in clear cycle 3: entries 0..2 become FILL, outputs return to reset values.
        for (int i = 1; i < 8; i++) a_push1(32'hB000_0000 + 32'(i));
        check("pre_abort_count", a_count, 4'd8);
        a_read(3'd2, 32'hB000_0002, "pre_abort_rd2");
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", a_busy, 1'b0);
        check("abort_count", a_count, 4'd0);
        check("abort_full", a_full, 1'b0);
        check("abort_ovf", a_ovf, 1'b0);
        check("abort_rdata", a_rdata, 32'h0);
        check("abort_rvalid", a_rd_valid, 1'b0);
        for (int a = 0; a < 3; a++) a_read(3'(a), 32'hFFFF_FFFF, $sformatf("abort_fill%0d", a));

        // 16 x 40 instance: 16 accepted pushes, 17th while full.
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("b_clr_done", b_busy, 1'b0);
        for (int i = 0; i < 17; i++) begin
            b_push  = 1'b1;
            b_pdata = 40'hC0_0000_0000 + 40'(i);
            tick();
        end
        b_push = 1'b0;
        check("b_count", b_count, 5'd16);
        check("b_full", b_full, 1'b1);
        check("b_ovf", b_ovf, OVF_EN);
        b_rd_en = 1'b1;
        b_raddr = 4'd15;
        tick();
        b_rd_en = 1'b0;
        check("b_rd15", b_rdata, 40'hC0_0000_000F);
        check("b_rd15_valid", b_rd_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppu_oam2_buf.md
# ppu_oam2_buf

Parametrised secondary-OAM buffer for the PPU sprite pipeline. Sprite evaluation appends in-range sprite entries through a push port; sprite fetch reads them back by index. The block tracks fill count, full, and sprite overflow. It also runs a hardware clear sequence that fills every entry with a fill value. It generalises the fixed 8×32 secondary OAM to arbitrary depth and entry width, so extended sprite-per-line modes use the same block.

## Interface
- DEPTH, 8, number of entries (power of two, ≥2)
- ENTRY_W, 32, bits per entry
- FILL, {ENTRY_W{1'b1}}, value written by the clear sequence
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_clear_start  in  1  one-cycle pulse that starts the clear sequence
- o_clear_busy  out  1  clear sequence in progress
- i_push  in  1  append i_push_data at the write pointer
- i_push_data  in  ENTRY_W  entry to append
- o_full  out  1  o_count == DEPTH
- o_count  out  $clog2(DEPTH)+1  number of entries pushed since the last clear
- o_overflow  out  1  sticky flag: a push was attempted while full
- i_rd_en  in  1  read strobe
- i_rd_addr  in  $clog2(DEPTH)  entry index to read
- o_rd_data  out  ENTRY_W  registered read data
- o_rd_valid  out  1  o_rd_data is valid this cycle

## Operation
- FSM states: S_IDLE, S_CLEAR.
- S_IDLE + i_clear_start → S_CLEAR. The clear counter, o_count and o_overflow are zeroed on the same edge.
- S_CLEAR writes FILL into entry k on the k-th cycle (k = 0..DEPTH-1). After entry DEPTH-1 is written → S_IDLE.
- i_clear_start while in S_CLEAR restarts the sequence at entry 0.
- Pushes are accepted only in S_IDLE with o_full = 0. An accepted push writes entry o_count and increments o_count.
- Push while full: data is dropped, o_count holds, o_overflow sets.
- Push during S_CLEAR: dropped. No flag change.
- i_push and i_clear_start in the same cycle: the clear wins and the push is dropped.
- Reads are allowed in any state. Each read returns the stored entry, regardless of o_count.
- o_full = (o_count == DEPTH), combinational from o_count.
- o_count saturates at DEPTH. No wrap-around.

## Timing
- Reset values: o_clear_busy=0, o_full=0, o_count=0, o_overflow=0, o_rd_data=0, o_rd_valid=0, state=S_IDLE.
- Memory contents are not reset. They are undefined until the first clear or push.
- Reset mid-clear aborts the sequence. Entries already written keep FILL.
- Read latency is 1: i_rd_en in cycle N → o_rd_data and o_rd_valid=1 in cycle N+1.
- Without i_rd_en: o_rd_valid=0 and o_rd_data holds its last value.
- Read and write to the same entry in the same cycle: the read returns the old contents (read-before-write).
- o_clear_busy is high for exactly DEPTH cycles, from the cycle after i_clear_start.
- A push is accepted no earlier than the first cycle in which o_clear_busy=0.
- Push in cycle N: o_count and o_full update in N+1. The data is readable by a read issued in N+1.
- Overflow attempt in cycle N: o_overflow=1 in N+1. It stays set until reset or the next i_clear_start.

## Configuration
- Macro: PPU_OAM2_OVERFLOW_EN.
- Defined: o_overflow behaves as described above.
- Undefined: o_overflow is tied to 0 and no flag register is built. Pushes while full are still dropped silently.

## Structure
- Shared package ppu_pkg holds:
  - the OAM2_DEPTH_DEF and OAM2_ENTRY_W_DEF constants;
  - the OAM2_FILL constant;
  - the state enum typedef oam2_state_t.
- Sub-module ppu_oam2_ram holds the storage: DEPTH×ENTRY_W, one write port, one registered read port, read-before-write.
- The FSM, pointers and flags live in the top level.

## Test plan
- Reset, then clear_start → o_clear_busy high for 8 cycles; every address then reads 0xFFFFFFFF one cycle after i_rd_en.
- Push 0x11223344, 0x55667788 → o_count=2, o_full=0; reading addr 1 gives 0x55667788 with o_rd_valid=1 one cycle later.
- Push 9 entries (DEPTH=8) → o_count=8, o_full=1, o_overflow=1; addr 7 holds the 8th entry; clear_start resets o_count and o_overflow to 0.
- Push and clear_start in the same cycle → push dropped, o_count=0, clear runs the full 8 cycles.
- i_rst asserted at clear cycle 3 → all outputs at reset values next cycle; entries 0..2 read FILL.
- DEPTH=16, ENTRY_W=40 build → 16 pushes accepted, o_count=16 (5 bits), 17th push sets o_overflow; with the macro undefined, o_overflow stays 0.
